// File: rtl/sim_block_accum_pkg.sv
// Shared definitions for the similarity-score accumulators.
// Provides the score width, default accumulator/index widths and a saturating
// adder reused by the block, row and column accumulators.
package sim_block_accum_pkg;

  localparam int unsigned SCORE_W       = 8;
  localparam int unsigned SUM_W_DEFAULT = 16;
  localparam int unsigned IDX_W_DEFAULT = 8;

  // Saturating add clamped to 2^w-1 (w < 32).
  // Bit 32 of the result flags that the true sum exceeded the limit;
  // bits 31:0 carry the clamped sum.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (s > lim) begin
      return {1'b1, lim[31:0]};
    end
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/sim_block_accum_best_tracker.sv
// Best-block tracker: keeps the largest block sum of the current frame and
// the index of the block that produced it. Ties keep the earliest block.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   clear_i         frame start; forgets the current best before any update
//   upd_valid_i     a block completed this cycle
//   upd_sum_i       final (saturated) sum of that block
//   upd_idx_i       index of that block
//   best_valid_o    at least one block seen since clear/reset
//   best_sum_o      largest sum so far
//   best_idx_o      index of that block
module sim_block_accum_best_tracker
  import sim_block_accum_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEFAULT,
  parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             upd_valid_i,
  input  logic [SUM_W-1:0] upd_sum_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic             best_valid_o,
  output logic [SUM_W-1:0] best_sum_o,
  output logic [IDX_W-1:0] best_idx_o
);

  logic             valid_q, valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    // A clear applies first so a block ending on the same cycle becomes best.
    valid_d = clear_i ? 1'b0 : valid_q;
    sum_d   = clear_i ? '0 : sum_q;
    idx_d   = clear_i ? '0 : idx_q;
    if (upd_valid_i && (!valid_d || (upd_sum_i > sum_d))) begin
      valid_d = 1'b1;
      sum_d   = upd_sum_i;
      idx_d   = upd_idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
    end
  end

  assign best_valid_o = valid_q;
  assign best_sum_o   = sum_q;
  assign best_idx_o   = idx_q;

endmodule

// File: rtl/sim_block_accum.sv
// Block accumulator for the per-pixel similarity stream.
// Sums 8-bit scores over blocks delimited by in_last, reports each block's
// saturated sum, index, threshold hit and saturation flag one cycle after the
// last beat, and tracks the best block of the frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              clears block index, accumulator and best tracker
//   in_valid/in_data/in_last score stream (in_last qualified by in_valid)
//   thr                      hit threshold, sampled on the last beat
//   out_valid                one-cycle result strobe
//   out_sum/idx/hit/sat      block result, held until the next block end
//   best_valid/sum/idx       best block of the current frame
module sim_block_accum
  import sim_block_accum_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEFAULT,
  parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [SCORE_W-1:0] in_data,
  input  logic               in_last,
  input  logic [SUM_W-1:0]   thr,
  output logic               out_valid,
  output logic [SUM_W-1:0]   out_sum,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_hit,
  output logic               out_sat,
  output logic               best_valid,
  output logic [SUM_W-1:0]   best_sum,
  output logic [IDX_W-1:0]   best_idx
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_hit_q, out_hit_d;
  logic             out_sat_q, out_sat_d;

  // Block state as seen after an optional frame_start clear.
  logic [SUM_W-1:0] base_acc;
  logic             base_sat;
  logic [IDX_W-1:0] base_idx;
  logic [32:0]      add_res;
  logic [SUM_W-1:0] sum_next;
  logic             sat_next;
  logic             blk_end;

  always_comb begin
    base_acc = frame_start ? '0 : acc_q;
    base_sat = frame_start ? 1'b0 : sat_q;
    base_idx = frame_start ? '0 : idx_q;
    add_res  = sat_add(32'(base_acc), 32'(in_data), SUM_W);
    sum_next = add_res[SUM_W-1:0];
    sat_next = base_sat | add_res[32];
    blk_end  = in_valid & in_last;

    acc_d       = base_acc;
    sat_d       = base_sat;
    idx_d       = base_idx;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_hit_d   = out_hit_q;
    out_sat_d   = out_sat_q;

    if (blk_end) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_next;
      out_idx_d   = base_idx;
      out_hit_d   = (sum_next >= thr);
      out_sat_d   = sat_next;
      acc_d       = '0;
      sat_d       = 1'b0;
      idx_d       = base_idx + IDX_W'(1);
    end else if (in_valid) begin
      acc_d = sum_next;
      sat_d = sat_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_hit_q   <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_hit_q   <= out_hit_d;
      out_sat_q   <= out_sat_d;
    end
  end

  sim_block_accum_best_tracker #(
    .SUM_W(SUM_W),
    .IDX_W(IDX_W)
  ) u_best_tracker (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (frame_start),
    .upd_valid_i (blk_end),
    .upd_sum_i   (sum_next),
    .upd_idx_i   (base_idx),
    .best_valid_o(best_valid),
    .best_sum_o  (best_sum),
    .best_idx_o  (best_idx)
  );

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_hit   = out_hit_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sim_block_accum.sv
// Drives a 16-bit and a 10-bit accumulator with the same stream and checks
// both against a reference model built on unbounded block totals.
module tb_sim_block_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic [15:0] thr;

  logic        ov0, hit0, sat0, bv0;
  logic [15:0] sum0, bs0;
  logic [7:0]  idx0, bi0;
  logic        ov1, hit1, sat1, bv1;
  logic [9:0]  sum1, bs1;
  logic [7:0]  idx1, bi1;

  always #5 clk = ~clk;

  sim_block_accum #(.SUM_W(16), .IDX_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .thr(thr),
    .out_valid(ov0), .out_sum(sum0), .out_idx(idx0), .out_hit(hit0), .out_sat(sat0),
    .best_valid(bv0), .best_sum(bs0), .best_idx(bi0)
  );

  sim_block_accum #(.SUM_W(10), .IDX_W(8)) u_dut10 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .thr(thr[9:0]),
    .out_valid(ov1), .out_sum(sum1), .out_idx(idx1), .out_hit(hit1), .out_sat(sat1),
    .best_valid(bv1), .best_sum(bs1), .best_idx(bi1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state per instance: [0] = 16-bit, [1] = 10-bit.
  longint m_true[2];
  longint m_lim[2];
  int     m_blk[2];
  int     e_ov[2], e_sum[2], e_idx[2], e_hit[2], e_sat[2];
  int     e_bv[2], e_bs[2], e_bi[2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_true[k] = 0; m_blk[k] = 0;
      e_ov[k] = 0; e_sum[k] = 0; e_idx[k] = 0; e_hit[k] = 0; e_sat[k] = 0;
      e_bv[k] = 0; e_bs[k] = 0; e_bi[k] = 0;
    end
  endtask

  // A block's saturated sum is min(total, limit); it saturated iff total > limit.
  task automatic model_step(input bit fs, input bit v, input int d, input bit last,
                            input int t, input bit r);
    longint fin;
    if (r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      e_ov[k] = 0;
      if (fs) begin
        m_true[k] = 0; m_blk[k] = 0;
        e_bv[k] = 0; e_bs[k] = 0; e_bi[k] = 0;
      end
      if (v) begin
        m_true[k] += d;
        if (last) begin
          fin       = (m_true[k] > m_lim[k]) ? m_lim[k] : m_true[k];
          e_ov[k]   = 1;
          e_sum[k]  = int'(fin);
          e_idx[k]  = m_blk[k];
          e_hit[k]  = (fin >= (longint'(t) & m_lim[k])) ? 1 : 0;
          e_sat[k]  = (m_true[k] > m_lim[k]) ? 1 : 0;
          if (e_bv[k] == 0 || fin > e_bs[k]) begin
            e_bv[k] = 1; e_bs[k] = int'(fin); e_bi[k] = m_blk[k];
          end
          m_blk[k]  = (m_blk[k] + 1) % 256;
          m_true[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp_one(input int k, input int ov, input int s, input int ix, input int h,
                         input int st, input int bv, input int bs, input int bi);
    string p;
    p = (k == 0) ? "w16" : "w10";
    check({p, ".out_valid"},  ov, e_ov[k]);
    check({p, ".out_sum"},    s,  e_sum[k]);
    check({p, ".out_idx"},    ix, e_idx[k]);
    check({p, ".out_hit"},    h,  e_hit[k]);
    check({p, ".out_sat"},    st, e_sat[k]);
    check({p, ".best_valid"}, bv, e_bv[k]);
    check({p, ".best_sum"},   bs, e_bs[k]);
    check({p, ".best_idx"},   bi, e_bi[k]);
  endtask

  task automatic step(input bit fs, input bit v, input int d, input bit last,
                      input int t, input bit r);
    frame_start = fs; in_valid = v; in_data = d[7:0]; in_last = last;
    thr = t[15:0]; rst = r;
    @(posedge clk);
    model_step(fs, v, d, last, t, r);
    #1;
    cmp_one(0, int'(ov0), int'(sum0), int'(idx0), int'(hit0), int'(sat0),
            int'(bv0), int'(bs0), int'(bi0));
    cmp_one(1, int'(ov1), int'(sum1), int'(idx1), int'(hit1), int'(sat1),
            int'(bv1), int'(bs1), int'(bi1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_lim[0] = 65535;
    m_lim[1] = 1023;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(1);

    // Four beats of 255, threshold 1000.
    for (int i = 0; i < 4; i++) step(0, 1, 255, i == 3, 1000, 0);
    idle(2);

    // New frame: blocks [10,20], [50], [30,30], then tie block [60].
    step(1, 0, 0, 0, 60, 0);
    step(0, 1, 10, 0, 60, 0); step(0, 1, 20, 1, 60, 0);
    step(0, 1, 50, 1, 60, 0);
    step(0, 1, 30, 0, 60, 0); step(0, 1, 30, 1, 60, 0);
    step(0, 1, 60, 1, 60, 0);
    idle(1);

    // Saturation on the 10-bit instance, then a block that does not saturate.
    for (int i = 0; i < 5; i++) step(0, 1, 255, i == 4, 500, 0);
    step(0, 1, 1, 1, 500, 0);
    idle(1);

    // Gaps with a stray in_last while in_valid is low.
    step(0, 1, 100, 0, 150, 0);
    step(0, 0, 0, 0, 150, 0);
    step(0, 0, 0, 1, 150, 0);
    step(0, 0, 0, 0, 150, 0);
    step(0, 1, 100, 1, 150, 0);
    idle(1);

    // frame_start coincident with a single-sample block.
    step(1, 1, 7, 1, 5, 0);
    idle(1);

    // Reset mid-block, then a fresh block.
    step(0, 1, 200, 0, 0, 0);
    step(0, 1, 200, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 1, 5, 1, 0, 0);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit fs, v, last, r;
      int d;
      r    = ($urandom_range(0, 199) == 0);
      fs   = ($urandom_range(0, 59) == 0);
      v    = ($urandom_range(0, 9) < 7);
      last = ($urandom_range(0, 5) == 0);
      d    = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      step(fs, v, d, last, int'($urandom_range(0, 3000)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
